// File: rtl/arithmetic_logic_unit_if.sv
// Operand/control/result bundle for arithmetic_logic_unit.
// The master drives operands and control and reads the registered result and
// flags; the slave (the ALU) does the reverse. There is no handshake: a new
// operation is accepted on every rising clock edge.
interface arithmetic_logic_unit_if;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [3:0]  Cntrl;
    logic [4:0]  Shamt;
    logic [31:0] ALU_OUT;
    logic        NF_OUT;
    logic        ZF_OUT;
    logic        OF_OUT;
    logic        BF_OUT;

    modport master (
        output Operand1, Operand2, Cntrl, Shamt,
        input  ALU_OUT, NF_OUT, ZF_OUT, OF_OUT, BF_OUT
    );

    modport slave (
        input  Operand1, Operand2, Cntrl, Shamt,
        output ALU_OUT, NF_OUT, ZF_OUT, OF_OUT, BF_OUT
    );
endinterface

// File: rtl/arithmetic_logic_unit.sv
// Registered 32-bit integer ALU for the multi-cycle MIPS datapath.
// Logic, add/sub, set-less-than and constant/variable shifts, with negative,
// zero, signed-overflow and bad-opcode flags. One cycle of latency.
// Optional feature macro: ALU_SLT_EN enables signed SLT on code 4'b0111;
// without it that code is reported as a bad opcode.
module arithmetic_logic_unit (
    input  logic                         CLK,
    input  logic                         RST,
    arithmetic_logic_unit_if.slave       bus
);
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_of;
    logic        w_bf;

    logic [31:0] r_alu_out;
    logic        r_nf;
    logic        r_zf;
    logic        r_of;
    logic        r_bf;

    assign w_a    = bus.Operand1;
    assign w_b    = bus.Operand2;
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;

    // Select the next result and the op-specific overflow / bad-opcode flags.
    always_comb begin
        w_result = 32'd0;
        w_of     = 1'b0;
        w_bf     = 1'b0;
        case (bus.Cntrl)
            4'b0000: w_result = w_a & w_b;
            4'b0001: w_result = w_a | w_b;
            4'b0010: begin
                w_result = w_sum;
                w_of     = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
            end
            4'b0011: w_result = w_a ^ w_b;
            4'b0100: w_result = ~(w_a | w_b);
            4'b0101: w_result = {31'd0, (w_a < w_b)};
            4'b0110: begin
                w_result = w_diff;
                w_of     = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
            end
`ifdef ALU_SLT_EN
            4'b0111: w_result = {31'd0, ($signed(w_a) < $signed(w_b))};
`else
            4'b0111: w_bf = 1'b1;
`endif
            4'b1000: w_result = w_b << bus.Shamt;
            4'b1001: w_result = w_b << w_a[4:0];
            4'b1010: w_result = w_b >> bus.Shamt;
            4'b1011: w_result = w_b >> w_a[4:0];
            4'b1100: w_result = $unsigned($signed(w_b) >>> bus.Shamt);
            4'b1101: w_result = $unsigned($signed(w_b) >>> w_a[4:0]);
            default: w_bf = 1'b1;
        endcase
    end

    // Capture result and flags; reset leaves a zero result with ZF set to match.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alu_out <= 32'd0;
            r_nf      <= 1'b0;
            r_zf      <= 1'b1;
            r_of      <= 1'b0;
            r_bf      <= 1'b0;
        end else begin
            r_alu_out <= w_result;
            r_nf      <= w_result[31];
            r_zf      <= (w_result == 32'd0);
            r_of      <= w_of;
            r_bf      <= w_bf;
        end
    end

    assign bus.ALU_OUT = r_alu_out;
    assign bus.NF_OUT  = r_nf;
    assign bus.ZF_OUT  = r_zf;
    assign bus.OF_OUT  = r_of;
    assign bus.BF_OUT  = r_bf;
endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed bench for arithmetic_logic_unit: hand-computed vectors applied in
// one linear sequence, each result checked one edge later with immediate asserts.
module tb_arithmetic_logic_unit;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    localparam logic [31:0] A_DEF = 32'hAAAAAAAA;
    localparam logic [31:0] B_DEF = 32'h55555555;

    arithmetic_logic_unit_if alu_bus ();

    arithmetic_logic_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (alu_bus.slave)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_out,
                             input logic e_nf, input logic e_zf,
                             input logic e_of, input logic e_bf);
        check({tag, ".out"}, alu_bus.ALU_OUT, e_out);
        check({tag, ".nf"},  {31'd0, alu_bus.NF_OUT}, {31'd0, e_nf});
        check({tag, ".zf"},  {31'd0, alu_bus.ZF_OUT}, {31'd0, e_zf});
        check({tag, ".of"},  {31'd0, alu_bus.OF_OUT}, {31'd0, e_of});
        check({tag, ".bf"},  {31'd0, alu_bus.BF_OUT}, {31'd0, e_bf});
    endtask

    // Drive inputs after a falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [4:0] sh);
        @(negedge clk);
        alu_bus.Operand1 = a;
        alu_bus.Operand2 = b;
        alu_bus.Cntrl    = c;
        alu_bus.Shamt    = sh;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        // Reset must win over a live operation that would give a nonzero result.
        alu_bus.Operand1 = 32'h7FFFFFFF;
        alu_bus.Operand2 = 32'd1;
        alu_bus.Cntrl    = 4'b0010;
        alu_bus.Shamt    = 5'd0;
        @(posedge clk);
        #1;
        check_all("reset", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Logic ops
        step(A_DEF, B_DEF, 4'b0000, 5'd0);  check_all("and",  32'h00000000, 0, 1, 0, 0);
        step(A_DEF, B_DEF, 4'b0001, 5'd0);  check_all("or",   32'hFFFFFFFF, 1, 0, 0, 0);
        step(A_DEF, B_DEF, 4'b0011, 5'd0);  check_all("xor",  32'hFFFFFFFF, 1, 0, 0, 0);
        step(A_DEF, B_DEF, 4'b0100, 5'd0);  check_all("nor",  32'h00000000, 0, 1, 0, 0);

        // Arithmetic
        step(A_DEF, B_DEF, 4'b0010, 5'd0);  check_all("add",  32'hFFFFFFFF, 1, 0, 0, 0);
        step(A_DEF, B_DEF, 4'b0110, 5'd0);  check_all("sub",  32'h55555555, 0, 0, 1, 0);
        step(32'h7FFFFFFF, 32'd1, 4'b0010, 5'd0); check_all("add_ovf", 32'h80000000, 1, 0, 1, 0);
        step(32'd5, 32'd7, 4'b0110, 5'd0);  check_all("sub_neg", 32'hFFFFFFFE, 1, 0, 0, 0);
        step(32'h80000000, 32'h80000000, 4'b0010, 5'd0); check_all("add_negovf", 32'h00000000, 0, 1, 1, 0);

        // Compare
        step(A_DEF, B_DEF, 4'b0101, 5'd0);  check_all("sltu", 32'd0, 0, 1, 0, 0);
        step(32'd1, 32'hFFFFFFFF, 4'b0101, 5'd0); check_all("sltu_true", 32'd1, 0, 0, 0, 0);
`ifdef ALU_SLT_EN
        step(32'hFFFFFFFF, 32'd1, 4'b0111, 5'd0); check_all("slt", 32'd1, 0, 0, 0, 0);
        step(32'd1, 32'hFFFFFFFF, 4'b0111, 5'd0); check_all("slt_false", 32'd0, 0, 1, 0, 0);
`else
        step(32'hFFFFFFFF, 32'd1, 4'b0111, 5'd0); check_all("slt_off", 32'd0, 0, 1, 0, 1);
`endif

        // Shifts
        step(A_DEF, B_DEF, 4'b1000, 5'd3);  check_all("sll",  32'hAAAAAAA8, 1, 0, 0, 0);
        step(A_DEF, B_DEF, 4'b1010, 5'd9);  check_all("srl",  32'h002AAAAA, 0, 0, 0, 0);
        step(A_DEF, B_DEF, 4'b1001, 5'd0);  check_all("sllv", 32'h55555400, 0, 0, 0, 0);
        step(32'd4, 32'hAAAAAAAA, 4'b1101, 5'd0); check_all("srav", 32'hFAAAAAAA, 1, 0, 0, 0);
        step(A_DEF, B_DEF, 4'b1100, 5'd10); check_all("sra",  32'h00155555, 0, 0, 0, 0);
        step(32'hFFFFFFE0, 32'h12345678, 4'b1001, 5'd7); check_all("sllv_zero", 32'h12345678, 0, 0, 0, 0);
        step(32'h0000003F, 32'h80000000, 4'b1011, 5'd0); check_all("srlv_31", 32'h00000001, 0, 0, 0, 0);
        step(32'd0, 32'h80000000, 4'b1100, 5'd31); check_all("sra_31", 32'hFFFFFFFF, 1, 0, 0, 0);

        // Invalid codes, then recovery
        step(A_DEF, B_DEF, 4'b1111, 5'd0);  check_all("bad_f", 32'd0, 0, 1, 0, 1);
        step(A_DEF, B_DEF, 4'b1110, 5'd0);  check_all("bad_e", 32'd0, 0, 1, 0, 1);
        // Mid-cycle input change must not disturb the held outputs.
        alu_bus.Cntrl = 4'b0001;
        #2;
        check_all("hold", 32'd0, 0, 1, 0, 1);
        step(A_DEF, B_DEF, 4'b0000, 5'd0);  check_all("recover", 32'd0, 0, 1, 0, 0);

        // Reset in mid-stream overrides an OR that would give all ones.
        step(A_DEF, B_DEF, 4'b0001, 5'd0);  check_all("or2", 32'hFFFFFFFF, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset2", 32'd0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
